// File: rtl/regfile_fwd_sb.sv
// Parametrised register file with same-cycle write-to-read forwarding and a
// per-register busy scoreboard with a registered population count.
module regfile_fwd_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     ctrl_writeEnable,
  input  logic [ADDR_W-1:0]        ctrl_writeReg,
  input  logic [DATA_W-1:0]        data_writeReg,
  input  logic [NUM_RD*ADDR_W-1:0] ctrl_readReg,
  output logic [NUM_RD*DATA_W-1:0] data_readReg,
  input  logic                     ctrl_issueEnable,
  input  logic [ADDR_W-1:0]        ctrl_issueReg,
  output logic [NUM_RD-1:0]        busy_readReg,
  output logic [ADDR_W:0]          busy_count
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CW-1:0]     busy_count_q, busy_count_d;
  logic              wr_en, iss_en, cnt_inc, cnt_dec;

  // With a hardwired zero register, index 0 never accepts data or a producer.
  assign wr_en  = ctrl_writeEnable && !((ZERO_REG != 0) && (ctrl_writeReg == '0));
  assign iss_en = ctrl_issueEnable && !((ZERO_REG != 0) && (ctrl_issueReg == '0));

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[ctrl_writeReg] = data_writeReg;
      busy_d[ctrl_writeReg] = 1'b0;
    end
    // Issue after write so a new producer on the same register keeps it busy.
    if (iss_en) busy_d[ctrl_issueReg] = 1'b1;
    cnt_inc = iss_en && !busy_q[ctrl_issueReg];
    cnt_dec = wr_en && busy_q[ctrl_writeReg] &&
              !(iss_en && (ctrl_issueReg == ctrl_writeReg));
    busy_count_d = busy_count_q + CW'(cnt_inc) - CW'(cnt_dec);
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  genvar k;
  for (k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic              fwd;
    assign idx = ctrl_readReg[k*ADDR_W +: ADDR_W];
    assign fwd = ctrl_writeEnable && (ctrl_writeReg == idx);
    assign data_readReg[k*DATA_W +: DATA_W] =
      (ctrl_reset || ((ZERO_REG != 0) && (idx == '0))) ? '0 :
      fwd ? data_writeReg : regs_q[idx];
    // A value being written this cycle is forwarded, so it is not reported busy.
    assign busy_readReg[k] = !ctrl_reset && busy_q[idx] && !fwd;
  end

endmodule
